// File: rtl/bram_stream_reader_pkg.sv
// Shared types for the BRAM-to-stream burst reader.
package bram_stream_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying words read out of the BRAM.
interface bram_stream_reader_if #(
    parameter int WIDTH = 12
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM with a registered (one clk) read.
module bram_sdp #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk_write,
    input  logic             we,
    input  logic [DEPTH-1:0] addr_write,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clk_read,
    input  logic [DEPTH-1:0] addr_read,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] mem [2**DEPTH];

    always_ff @(posedge clk_write)
        if (we) mem[addr_write] <= data_in;

    always_ff @(posedge clk_read)
        data_out <= mem[addr_read];
endmodule

// File: rtl/stream_skid2.sv
// Two-entry FIFO absorbing BRAM read data while the sink stalls.
module stream_skid2
    import bram_stream_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);
    logic [1:0][WIDTH-1:0] buf_q;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            cnt;
    logic                  push;
    logic                  pop;

    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign in_ready  = (cnt != 2'(SKID_DEPTH)) || out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = buf_q[rd_ptr];
    assign level     = cnt;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= in_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// Reads len consecutive BRAM words from base_addr and emits them on a
// valid/ready stream, throttling reads so the skid FIFO never overflows.
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DEPTH-1:0]     base_addr,
    input  logic [DEPTH:0]       len,
    output logic [DEPTH-1:0]     addr_read,
    input  logic [WIDTH-1:0]     data_out,
    bram_stream_reader_if.master m,
    output logic                 busy,
    output logic                 done
);
    localparam logic [DEPTH:0] ONE = {{DEPTH{1'b0}}, 1'b1};

    state_t         state, state_nxt;
    logic [DEPTH:0] len_q;
    logic [DEPTH:0] issued;
    logic [DEPTH:0] accepted;
    logic           rd_vld;
    logic           issue;
    logic           room;
    logic           pop;
    logic           last_pop;
    logic [1:0]     level;
    logic           fifo_in_ready;

    stream_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_vld),
        .in_ready  (fifo_in_ready),
        .in_data   (data_out),
        .out_valid (m.m_valid),
        .out_ready (m.m_ready),
        .out_data  (m.m_data),
        .level     (level)
    );

    assign pop      = m.m_valid && m.m_ready;
    assign last_pop = pop && (state != IDLE) && (accepted == len_q - ONE);
    // Occupancy counted after this cycle's pop, so a steady sink sees one word per clk.
    assign room     = (3'(level) + 3'(rd_vld)) < (3'd2 + 3'(pop));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:  if (start && (len != '0)) state_nxt = RUN;
            RUN: begin
                issue = (issued != len_q) && room && fifo_in_ready;
                if (issue && (issued + ONE == len_q)) state_nxt = DRAIN;
            end
            DRAIN: if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            issued    <= '0;
            accepted  <= '0;
            addr_read <= '0;
            rd_vld    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_vld <= issue;
            if (state == IDLE) begin
                if (start) begin
                    len_q     <= len;
                    addr_read <= base_addr;
                    issued    <= '0;
                    accepted  <= '0;
                    done      <= (len == '0);
                end
            end else begin
                if (issue) begin
                    addr_read <= addr_read + 1'b1;
                    issued    <= issued + ONE;
                end
                if (pop)      accepted <= accepted + ONE;
                if (last_pop) done     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench: bursts push expected words, a negedge monitor checks the stream.
module tb_bram_stream_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  len = '0;
    logic [7:0]  addr_read;
    logic [11:0] data_out;
    logic        busy, done;
    logic        we = 1'b0;
    logic [7:0]  addr_write = '0;
    logic [11:0] data_in = '0;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [11:0] exp_q [$];
    logic [11:0] model [256];
    logic [7:0]  addr_hist [64];
    logic        prev_stall = 1'b0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    bram_stream_reader_if #(.WIDTH(12)) m_if ();

    bram_sdp #(.WIDTH(12), .DEPTH(8)) u_mem (
        .clk_write (clk), .we (we), .addr_write (addr_write), .data_in (data_in),
        .clk_read (clk), .addr_read (addr_read), .data_out (data_out)
    );

    bram_stream_reader #(.WIDTH(12), .DEPTH(8)) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .base_addr (base_addr),
        .len (len), .addr_read (addr_read), .data_out (data_out),
        .m (m_if.master), .busy (busy), .done (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) chk("stall_valid_hold", 32'(m_if.m_valid), 32'd1);
            if (m_if.m_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got data 0x%0h with no word expected at %0t",
                             m_if.m_data, $time);
                end else begin
                    chk("m_data", 32'(m_if.m_data), 32'(exp_q[0]));
                    if (m_if.m_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            if (done) begin
                chk("done_single_cycle", 32'(prev_done), 32'd0);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [11:0] d);
        we = 1'b1; addr_write = a; data_in = d;
        tick();
        we = 1'b0;
        model[a] = d;
    endtask

    // Drives start in the current window; returns in the window where done is high.
    task automatic run_burst(input logic [7:0] b, input logic [8:0] l, input logic [15:0] pat,
                             input bit mid, input bit full);
        int cyc = 0;
        int first_v = -1;
        int done_c = -1;
        for (int i = 0; i < int'(l); i++) exp_q.push_back(model[8'(int'(b) + i)]);
        base_addr = b; len = l; start = 1'b1; m_if.m_ready = pat[0];
        while (done_c < 0 && cyc < 100) begin
            tick();
            cyc++;
            start = mid && (cyc == 2);
            if (start) begin base_addr = 8'h40; len = 9'd4; end
            m_if.m_ready = (cyc < 16) ? pat[cyc] : 1'b1;
            if (cyc < 64) addr_hist[cyc] = addr_read;
            if (cyc == 1) chk("busy_after_start", 32'(busy), 32'(l != 0));
            if (l == 0) chk("len0_busy_low", 32'(busy), 32'd0);
            if (m_if.m_valid && first_v < 0) first_v = cyc;
            if (done) done_c = cyc;
        end
        if (done_c < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 100 cycles, expected a pulse");
        end else begin
            chk("busy_low_at_done", 32'(busy), 32'd0);
            if (l == 0) begin
                chk("len0_done_cycle", 32'(done_c), 32'd1);
                chk("len0_no_valid", 32'(first_v), 32'hFFFF_FFFF);
            end else if (full) begin
                chk("first_valid_latency", 32'(first_v), 32'd3);
                chk("done_cycle", 32'(done_c), 32'(l) + 32'd3);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int snap;
        for (int i = 0; i < 256; i++) model[i] = '0;
        m_if.m_ready = 1'b1;
        #1 rst_n = 1'b0;
        wr(8'h00, 12'h123); wr(8'h01, 12'h456); wr(8'h02, 12'h789); wr(8'h03, 12'hABC);
        wr(8'hFE, 12'h111); wr(8'hFF, 12'h222);
        chk("rst_addr_read", 32'(addr_read), 32'd0);
        chk("rst_m_valid", 32'(m_if.m_valid), 32'd0);
        chk("rst_m_data", 32'(m_if.m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // start is sampled on the very first edge after reset release
        rst_n = 1'b1;
        run_burst(8'h00, 9'd4, 16'hFFFF, 1'b0, 1'b1);
        start = 1'b0;
        tick(); tick();

        run_burst(8'h00, 9'd4, 16'b1111_1001_0100_1111, 1'b0, 1'b0);
        start = 1'b0; m_if.m_ready = 1'b1;
        tick(); tick();

        wr(8'h00, 12'h333); wr(8'h01, 12'h444);
        run_burst(8'hFE, 9'd4, 16'hFFFF, 1'b0, 1'b1);
        start = 1'b0;
        chk("wrap_addr_first", 32'(addr_hist[1]), 32'hFE);
        chk("wrap_addr_zero", 32'(addr_hist[3]), 32'h00);
        tick(); tick();

        run_burst(8'h10, 9'd0, 16'hFFFF, 1'b0, 1'b1);
        start = 1'b0;
        tick(); tick();

        run_burst(8'h02, 9'd2, 16'hFFFF, 1'b1, 1'b1);
        run_burst(8'h00, 9'd2, 16'hFFFF, 1'b0, 1'b1);
        start = 1'b0;
        tick(); tick();

        // reset while word 2 of a 4-word burst is on the stream
        for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
        base_addr = 8'h00; len = 9'd4; start = 1'b1; m_if.m_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("mid_word2_valid", 32'(m_if.m_valid), 32'd1);
        chk("mid_word2_data", 32'(m_if.m_data), 32'h444);
        snap = done_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_m_valid", 32'(m_if.m_valid), 32'd0);
        chk("abort_m_data", 32'(m_if.m_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr_read", 32'(addr_read), 32'd0);
        tick(); tick(); tick();
        chk("abort_no_done_pulse", 32'(done_cnt), 32'(snap));
        rst_n = 1'b1;
        run_burst(8'h02, 9'd2, 16'hFFFF, 1'b0, 1'b1);
        start = 1'b0;

        for (int i = 0; i < 5; i++) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("done_pulse_count", 32'(done_cnt), 32'd7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
